// File: rtl/multi_mode_flip_flop_bank_if.sv
// Purpose : Bundles the control, data and status signals of
//           multi_mode_flip_flop_bank so the driver and the bank share one
//           connection object.
// Modports: master - drives en/sync_clr/mode/a/b/err_clr, observes the state
//                    and the error status.
//           slave  - the flip-flop bank itself (the reverse directions).
// Signals : en, sync_clr, mode[1:0], a/b[WIDTH], err_clr   (master -> slave)
//           q, q_bar[WIDTH], illegal, illegal_bits[WIDTH],
//           illegal_count[CNT_WIDTH], sticky_err           (slave -> master)
interface multi_mode_flip_flop_bank_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 en;
  logic                 sync_clr;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 err_clr;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_bar;
  logic                 illegal;
  logic [WIDTH-1:0]     illegal_bits;
  logic [CNT_WIDTH-1:0] illegal_count;
  logic                 sticky_err;

  modport master (
    output en, sync_clr, mode, a, b, err_clr,
    input  q, q_bar, illegal, illegal_bits, illegal_count, sticky_err
  );

  modport slave (
    input  en, sync_clr, mode, a, b, err_clr,
    output q, q_bar, illegal, illegal_bits, illegal_count, sticky_err
  );
endinterface

// File: rtl/multi_mode_flip_flop_bank.sv
// Purpose : WIDTH-bit bank of edge-triggered flip-flops whose behaviour (SR,
//           JK, D or T) is chosen at run time for all bits at once. Also
//           detects SR inputs with S=R=1, reporting a one-cycle pulse, the
//           offending bit mask, a saturating event counter and a sticky flag.
// Ports   : clock - rising-edge clock
//           reset - asynchronous, active-high reset
//           bus   - slave side of multi_mode_flip_flop_bank_if
//                   (en, sync_clr, mode, a, b, err_clr in;
//                    q, q_bar, illegal, illegal_bits, illegal_count,
//                    sticky_err out)
module multi_mode_flip_flop_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               SR_POLICY   = 0,
  parameter int               CNT_WIDTH   = 8
) (
  input logic                          clock,
  input logic                          reset,
  multi_mode_flip_flop_bank_if.slave   bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     next_q_s;
  logic                 illegal_r;
  logic [WIDTH-1:0]     illegal_bits_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] count_base_s;
  logic [CNT_WIDTH-1:0] count_next_s;
  logic                 sticky_r;
  logic                 illegal_edge_s;

  // Resolution of S=R=1 for one bit; the result is always a defined level.
  function automatic logic sr_both_bit(input logic cur);
    logic res;
    case (SR_POLICY)
      1:       res = 1'b1;
      2:       res = 1'b0;
      default: res = cur;
    endcase
    return res;
  endfunction

  // An illegal edge only counts when the SR inputs would actually be used.
  assign illegal_edge_s = bus.en && !bus.sync_clr && (bus.mode == MODE_SR) &&
                          ((bus.a & bus.b) != {WIDTH{1'b0}});

  // Per-bit next state for the selected mode (en/sync_clr applied later).
  always_comb begin
    next_q_s = q_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (bus.mode)
        MODE_SR: begin
          case ({bus.a[i], bus.b[i]})
            2'b01:   next_q_s[i] = 1'b0;
            2'b10:   next_q_s[i] = 1'b1;
            2'b11:   next_q_s[i] = sr_both_bit(q_r[i]);
            default: next_q_s[i] = q_r[i];
          endcase
        end
        MODE_JK: begin
          case ({bus.a[i], bus.b[i]})
            2'b01:   next_q_s[i] = 1'b0;
            2'b10:   next_q_s[i] = 1'b1;
            2'b11:   next_q_s[i] = ~q_r[i];
            default: next_q_s[i] = q_r[i];
          endcase
        end
        MODE_D:  next_q_s[i] = bus.a[i];
        MODE_T:  next_q_s[i] = q_r[i] ^ bus.a[i];
        default: next_q_s[i] = q_r[i];
      endcase
    end
  end

  // Counter update: err_clr is applied before a same-edge illegal event.
  always_comb begin
    count_base_s = count_r;
    count_next_s = count_r;
    if (bus.err_clr) begin
      count_base_s = {CNT_WIDTH{1'b0}};
    end else begin
      count_base_s = count_r;
    end
    if (illegal_edge_s && (count_base_s != CNT_MAX)) begin
      count_next_s = count_base_s + CNT_WIDTH'(1);
    end else begin
      count_next_s = count_base_s;
    end
  end

  // Flip-flop state: sync_clr beats en, en = 0 holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_r <= RESET_VALUE;
    end else if (bus.sync_clr) begin
      q_r <= RESET_VALUE;
    end else if (bus.en) begin
      q_r <= next_q_s;
    end else begin
      q_r <= q_r;
    end
  end

  // Error status registers; independent of sync_clr except via the edge qualifier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_r      <= 1'b0;
      illegal_bits_r <= {WIDTH{1'b0}};
      count_r        <= {CNT_WIDTH{1'b0}};
      sticky_r       <= 1'b0;
    end else begin
      illegal_r      <= illegal_edge_s;
      illegal_bits_r <= illegal_edge_s ? (bus.a & bus.b) : {WIDTH{1'b0}};
      count_r        <= count_next_s;
      sticky_r       <= (sticky_r && !bus.err_clr) || illegal_edge_s;
    end
  end

  assign bus.q             = q_r;
  assign bus.q_bar         = ~q_r;
  assign bus.illegal       = illegal_r;
  assign bus.illegal_bits  = illegal_bits_r;
  assign bus.illegal_count = count_r;
  assign bus.sticky_err    = sticky_r;

endmodule

// File: tb/tb_multi_mode_flip_flop_bank.sv
module tb_multi_mode_flip_flop_bank;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic sync_clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic err_clr = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // p0: hold policy, p1: set-dominant, p2: reset-dominant, c2: 2-bit counter
  multi_mode_flip_flop_bank_if #(.WIDTH(8), .CNT_WIDTH(8)) if0 ();
  multi_mode_flip_flop_bank_if #(.WIDTH(8), .CNT_WIDTH(8)) if1 ();
  multi_mode_flip_flop_bank_if #(.WIDTH(8), .CNT_WIDTH(8)) if2 ();
  multi_mode_flip_flop_bank_if #(.WIDTH(8), .CNT_WIDTH(2)) if3 ();

  assign if0.en = en; assign if0.sync_clr = sync_clr; assign if0.mode = mode;
  assign if0.a = a;   assign if0.b = b;               assign if0.err_clr = err_clr;
  assign if1.en = en; assign if1.sync_clr = sync_clr; assign if1.mode = mode;
  assign if1.a = a;   assign if1.b = b;               assign if1.err_clr = err_clr;
  assign if2.en = en; assign if2.sync_clr = sync_clr; assign if2.mode = mode;
  assign if2.a = a;   assign if2.b = b;               assign if2.err_clr = err_clr;
  assign if3.en = en; assign if3.sync_clr = sync_clr; assign if3.mode = mode;
  assign if3.a = a;   assign if3.b = b;               assign if3.err_clr = err_clr;

  multi_mode_flip_flop_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_POLICY(0), .CNT_WIDTH(8))
    dut0 (.clock(clock), .reset(reset), .bus(if0));
  multi_mode_flip_flop_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_POLICY(1), .CNT_WIDTH(8))
    dut1 (.clock(clock), .reset(reset), .bus(if1));
  multi_mode_flip_flop_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_POLICY(2), .CNT_WIDTH(8))
    dut2 (.clock(clock), .reset(reset), .bus(if2));
  multi_mode_flip_flop_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_POLICY(0), .CNT_WIDTH(2))
    dut3 (.clock(clock), .reset(reset), .bus(if3));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv);
    en = e; mode = m; a = av; b = bv;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (if0.q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", if0.q); end
    checks++; if (if0.q_bar !== 8'h5A) begin errors++; $display("FAIL reset_qbar: got %h want 5a", if0.q_bar); end
    checks++; if (if0.illegal !== 1'b0 || if0.illegal_bits !== 8'h00) begin errors++; $display("FAIL reset_illegal: got %b/%h want 0/00", if0.illegal, if0.illegal_bits); end
    checks++; if (if0.illegal_count !== 8'h00 || if0.sticky_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %h/%b want 00/0", if0.illegal_count, if0.sticky_err); end
    checks++; if (if3.q !== 8'hA5 || if3.illegal_count !== 2'd0) begin errors++; $display("FAIL reset_dut3: got %h/%h want a5/0", if3.q, if3.illegal_count); end
    drive(1'b1, 2'b10, 8'h00, 8'h00);
    tick();
    checks++; if (if0.q !== 8'h00) begin errors++; $display("FAIL d_load00: got %h want 00", if0.q); end
    #2 reset = 1'b1;
    #1;
    checks++; if (if0.q !== 8'hA5 || if0.q_bar !== 8'h5A) begin errors++; $display("FAIL async_reset: got %h/%h want a5/5a", if0.q, if0.q_bar); end
    reset = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
  endtask

  task automatic test_sr_basic();
    drive(1'b1, 2'b10, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b00, 8'h0F, 8'h00);
    tick();
    checks++; if (if0.q !== 8'h0F) begin errors++; $display("FAIL sr_set: got %h want 0f", if0.q); end
    drive(1'b1, 2'b00, 8'h00, 8'h03);
    tick();
    checks++; if (if0.q !== 8'h0C) begin errors++; $display("FAIL sr_clear: got %h want 0c", if0.q); end
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    tick();
    checks++; if (if0.q !== 8'h0C) begin errors++; $display("FAIL sr_hold: got %h want 0c", if0.q); end
    drive(1'b0, 2'b00, 8'hFF, 8'h00);
    tick();
    checks++; if (if0.q !== 8'h0C || if0.q_bar !== 8'hF3) begin errors++; $display("FAIL sr_en0: got %h/%h want 0c/f3", if0.q, if0.q_bar); end
    checks++; if (if0.illegal !== 1'b0 || if0.sticky_err !== 1'b0) begin errors++; $display("FAIL sr_no_illegal: got %b/%b want 0/0", if0.illegal, if0.sticky_err); end
  endtask

  task automatic test_sr_illegal();
    drive(1'b1, 2'b10, 8'h3C, 8'h00);
    tick();
    drive(1'b1, 2'b00, 8'h81, 8'h81);
    tick();
    checks++; if (if0.q !== 8'h3C) begin errors++; $display("FAIL policy_hold: got %h want 3c", if0.q); end
    checks++; if (if1.q !== 8'hBD) begin errors++; $display("FAIL policy_set: got %h want bd", if1.q); end
    checks++; if (if2.q !== 8'h3C) begin errors++; $display("FAIL policy_reset: got %h want 3c", if2.q); end
    checks++; if (if0.illegal !== 1'b1 || if0.illegal_bits !== 8'h81) begin errors++; $display("FAIL illegal_pulse: got %b/%h want 1/81", if0.illegal, if0.illegal_bits); end
    checks++; if (if0.illegal_count !== 8'd1 || if0.sticky_err !== 1'b1) begin errors++; $display("FAIL illegal_count1: got %h/%b want 01/1", if0.illegal_count, if0.sticky_err); end
    drive(1'b1, 2'b00, 8'h00, 8'h00);
    tick();
    checks++; if (if0.illegal !== 1'b0 || if0.illegal_bits !== 8'h00) begin errors++; $display("FAIL illegal_drop: got %b/%h want 0/00", if0.illegal, if0.illegal_bits); end
    checks++; if (if0.sticky_err !== 1'b1 || if0.illegal_count !== 8'd1) begin errors++; $display("FAIL sticky_hold: got %b/%h want 1/01", if0.sticky_err, if0.illegal_count); end
  endtask

  task automatic test_modes();
    drive(1'b1, 2'b10, 8'hF0, 8'h00);
    tick();
    drive(1'b1, 2'b01, 8'hFF, 8'hFF);
    tick();
    checks++; if (if0.q !== 8'h0F || if0.illegal !== 1'b0) begin errors++; $display("FAIL jk_toggle1: got %h/%b want 0f/0", if0.q, if0.illegal); end
    tick();
    checks++; if (if0.q !== 8'hF0 || if0.illegal !== 1'b0) begin errors++; $display("FAIL jk_toggle2: got %h/%b want f0/0", if0.q, if0.illegal); end
    checks++; if (if0.illegal_count !== 8'd1) begin errors++; $display("FAIL jk_no_count: got %h want 01", if0.illegal_count); end
    drive(1'b1, 2'b10, 8'h5A, 8'hFF);
    tick();
    checks++; if (if0.q !== 8'h5A) begin errors++; $display("FAIL d_mode: got %h want 5a", if0.q); end
    drive(1'b1, 2'b11, 8'h0F, 8'hFF);
    tick();
    checks++; if (if0.q !== 8'h55 || if0.q_bar !== 8'hAA) begin errors++; $display("FAIL t_mode: got %h/%h want 55/aa", if0.q, if0.q_bar); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp3 [5];
    exp3[0] = 2'd1; exp3[1] = 2'd2; exp3[2] = 2'd3; exp3[3] = 2'd3; exp3[4] = 2'd3;
    drive(1'b0, 2'b10, 8'h00, 8'h00);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (if3.illegal_count !== 2'd0 || if3.sticky_err !== 1'b0) begin errors++; $display("FAIL pre_clear: got %h/%b want 0/0", if3.illegal_count, if3.sticky_err); end
    drive(1'b1, 2'b00, 8'h01, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (if3.illegal_count !== exp3[i]) begin errors++; $display("FAIL sat_count[%0d]: got %h want %h", i, if3.illegal_count, exp3[i]); end
    end
    checks++; if (if0.illegal_count !== 8'd5) begin errors++; $display("FAIL wide_count: got %h want 05", if0.illegal_count); end
    err_clr = 1'b1;
    tick();
    checks++; if (if3.illegal_count !== 2'd1 || if3.sticky_err !== 1'b1) begin errors++; $display("FAIL clr_and_event: got %h/%b want 1/1", if3.illegal_count, if3.sticky_err); end
    checks++; if (if0.illegal_count !== 8'd1) begin errors++; $display("FAIL clr_and_event_wide: got %h want 01", if0.illegal_count); end
    drive(1'b0, 2'b00, 8'h01, 8'h01);
    tick();
    err_clr = 1'b0;
    checks++; if (if3.illegal_count !== 2'd0 || if3.sticky_err !== 1'b0) begin errors++; $display("FAIL clr_alone: got %h/%b want 0/0", if3.illegal_count, if3.sticky_err); end
    checks++; if (if0.q !== 8'h55) begin errors++; $display("FAIL errclr_keeps_q: got %h want 55", if0.q); end
  endtask

  task automatic test_sync_clr();
    drive(1'b0, 2'b00, 8'hFF, 8'hFF);
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    checks++; if (if0.q !== 8'hA5 || if0.illegal !== 1'b0) begin errors++; $display("FAIL sync_clr_q: got %h/%b want a5/0", if0.q, if0.illegal); end
    checks++; if (if0.sticky_err !== 1'b0 || if0.illegal_count !== 8'd0) begin errors++; $display("FAIL sync_clr_noerr: got %b/%h want 0/00", if0.sticky_err, if0.illegal_count); end
    drive(1'b1, 2'b10, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b00, 8'h01, 8'h01);
    tick();
    checks++; if (if0.q !== 8'h00 || if0.sticky_err !== 1'b1) begin errors++; $display("FAIL pre_sync: got %h/%b want 00/1", if0.q, if0.sticky_err); end
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    sync_clr = 1'b1;
    tick();
    checks++; if (if0.q !== 8'hA5 || if0.illegal !== 1'b0) begin errors++; $display("FAIL sync_en1: got %h/%b want a5/0", if0.q, if0.illegal); end
    checks++; if (if0.sticky_err !== 1'b1 || if0.illegal_count !== 8'd1) begin errors++; $display("FAIL sync_keeps_err: got %b/%h want 1/01", if0.sticky_err, if0.illegal_count); end
    drive(1'b1, 2'b10, 8'h00, 8'h00);
    tick();
    drive(1'b1, 2'b00, 8'hFF, 8'hFF);
    err_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    err_clr = 1'b0;
    checks++; if (if0.q !== 8'hA5) begin errors++; $display("FAIL both_clr_q: got %h want a5", if0.q); end
    checks++; if (if0.sticky_err !== 1'b0 || if0.illegal_count !== 8'd0 || if0.illegal !== 1'b0) begin errors++; $display("FAIL both_clr_err: got %b/%h/%b want 0/00/0", if0.sticky_err, if0.illegal_count, if0.illegal); end
  endtask

  initial begin
    test_reset();
    test_sr_basic();
    test_sr_illegal();
    test_modes();
    test_saturation();
    test_sync_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_mode_flip_flop_bank.md
Name: multi_mode_flip_flop_bank

Overview:
- WIDTH-bit bank of edge-triggered flip-flops; one runtime mode select picks SR, JK, D or T behaviour for every bit.
- Successor to the single-bit SR flip-flop. Adds width, mode selection, clock enable, synchronous clear, and a deterministic S=R=1 policy (never X).
- Adds illegal-input detection with a per-bit mask, a saturating event counter and a sticky error flag.
- Used as a generic state/register primitive in control paths.

Parameters:
- WIDTH, 8, number of flip-flop bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset and on sync_clr.
- SR_POLICY, 0, action on S=R=1 in SR mode: 0 = hold, 1 = set-dominant, 2 = reset-dominant.
- CNT_WIDTH, 8, width of illegal_count.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  clock enable for q updates
- sync_clr  in  1  synchronous clear of q
- mode  in  2  00 = SR, 01 = JK, 10 = D, 11 = T
- a  in  WIDTH  S / J / D / T input per bit
- b  in  WIDTH  R / K input per bit; ignored in D and T modes
- err_clr  in  1  clears illegal_count and sticky_err
- q  out  WIDTH  flip-flop state
- q_bar  out  WIDTH  always the bitwise inverse of q
- illegal  out  1  registered pulse: illegal SR input on the previous edge
- illegal_bits  out  WIDTH  registered mask of offending bits
- illegal_count  out  CNT_WIDTH  saturating count of illegal edges
- sticky_err  out  1  set on any illegal edge; held until err_clr

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - q = RESET_VALUE, q_bar = ~RESET_VALUE.
  - illegal = 0, illegal_bits = 0, illegal_count = 0, sticky_err = 0.
  - Reset asserted mid-operation overrides everything at once; no partial update survives.
- q priority at each rising edge:
  - reset, then sync_clr (q = RESET_VALUE regardless of en), then en = 0 (hold), then the mode function.
- Per-bit next-state function, with i = bit index:
  - SR: 00 hold, 01 clear, 10 set, 11 per SR_POLICY.
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - D: q[i] = a[i].
  - T: q[i] = q[i] ^ a[i].
- Mode takes effect on the same edge it is sampled; there is no pipeline, and q latency is 1 cycle.
- q_bar is derived combinationally from q (~q), so it is never inconsistent with q and never X.
- Illegal event:
  - Defined per edge: en = 1, sync_clr = 0, mode = SR, and (a & b) != 0.
  - illegal_bits = a & b, registered on that edge; otherwise illegal_bits = 0.
  - illegal = |illegal_bits (a one-cycle pulse per illegal edge).
  - JK 11 is never illegal. Inputs are ignored while en = 0 or sync_clr = 1.
- illegal_count:
  - Increments by 1 per illegal edge (not per bit).
  - Saturates at 2^CNT_WIDTH - 1; no wrap-around.
- sticky_err: set on an illegal edge; cleared only by err_clr or reset.
- err_clr together with an illegal event on the same edge: the clear is applied first, then the event, giving illegal_count = 1 and sticky_err = 1.
- err_clr does not affect q; sync_clr does not affect the error logic.
- All outputs are registered except q_bar.

Test Plan:
1. Reset release with RESET_VALUE = 8'hA5: q = A5, q_bar = 5A, all error outputs 0. Assert reset between edges: q returns to A5 immediately, without waiting for a clock edge.
2. SR mode, en = 1, q = 00:
   - a = 0F, b = 00 gives q = 0F.
   - a = 00, b = 03 gives q = 0C.
   - a = b = 00 holds q = 0C.
   - en = 0 with a = FF holds q = 0C.
3. SR illegal, q = 3C, a = 81, b = 81:
   - SR_POLICY = 0 gives q = 3C; 1 gives q = BD; 2 gives q = 3C.
   - Next cycle: illegal = 1, illegal_bits = 81, illegal_count = 1, sticky_err = 1.
   - Following cycle: illegal = 0, sticky_err stays 1.
4. JK mode, q = F0, a = b = FF: q toggles to 0F, then F0, with illegal = 0 throughout. D mode, a = 5A: q = 5A. T mode, a = 0F: q = 55.
5. CNT_WIDTH = 2 with 5 consecutive illegal edges: count reads 1, 2, 3, 3, 3. err_clr on the same edge as a sixth illegal edge gives count = 1, sticky_err = 1. err_clr alone gives count = 0, sticky_err = 0.
6. sync_clr = 1 with en = 0, mode = SR, a = b = FF: q = RESET_VALUE and illegal stays 0. Then sync_clr and err_clr together: both apply independently.
